// File: rtl/uinstr_issue_ctrl.sv
// -----------------------------------------------------------------------------
// uinstr_issue_ctrl
//
// Issue controller that sits between a host instruction port and a microcode
// sequencer. It accepts one instruction at a time, steers the sequencer
// through dispatch and the control-memory read latency, then issues one
// micro-op per cycle from the control word (CW) until an end bit or an error.
//
// CW layout: [31:16] branch target (sequencer only), [15:14] next-address
// select (00 inc, 01 branch, 10 return, 11 illegal), [13] call, [12] end,
// [DP_WIDTH-1:0] datapath controls.
//
// Ports:
//   clk, reset_n                       clock, synchronous active-low reset
//   instr_valid/instr_ready            host handshake
//   instr_opcode/instr_f4/instr_f5     host instruction fields
//   CW                                 control word from control memory
//   stack_empty                        sequencer return-stack empty flag
//   err_clr                            leaves ERR and clears err_code
//   opcode/function4bit/function5bit   latched instruction fields
//   uCode_Addr                         next-address select to sequencer
//   stack_push/stack_pop/load_ret_addr return-stack strobes
//   dp_ctrl/dp_valid                   issued datapath controls
//   done, busy, err_code, uop_count    status
//
// Configuration macro: UOP_WATCHDOG_EN -- when defined, an instruction that
// issues MAX_UOPS micro-ops without an end bit goes to ERR with code 11.
//
// Timing note: the CW-dependent outputs (uCode_Addr, stack strobes, dp_ctrl,
// dp_valid) are decoded from the registered state and the current CW, because
// the sequencer needs the next-address select in the same cycle the control
// word is presented. All status outputs come straight from registers.
// -----------------------------------------------------------------------------
module uinstr_issue_ctrl #(
    parameter int STACK_DEPTH = 4,
    parameter int MAX_UOPS    = 1024,
    parameter int DP_WIDTH    = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [3:0]          instr_opcode,
    input  logic [3:0]          instr_f4,
    input  logic [4:0]          instr_f5,
    input  logic [31:0]         CW,
    input  logic                stack_empty,
    input  logic                err_clr,
    output logic [3:0]          opcode,
    output logic [3:0]          function4bit,
    output logic [4:0]          function5bit,
    output logic [1:0]          uCode_Addr,
    output logic                stack_push,
    output logic                stack_pop,
    output logic                load_ret_addr,
    output logic [DP_WIDTH-1:0] dp_ctrl,
    output logic                dp_valid,
    output logic                done,
    output logic                busy,
    output logic [1:0]          err_code,
    output logic [15:0]         uop_count
);

    localparam int              DW         = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0]   DEPTH_FULL = DW'(STACK_DEPTH);
    localparam logic [16:0]     WD_LIMIT   = 17'(MAX_UOPS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DISPATCH = 3'd1,
        S_WAIT     = 3'd2,
        S_EXEC     = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    state_t         state_q;
    logic [DW-1:0]  depth_q;
    logic [15:0]    uop_count_q;
    logic [1:0]     err_code_q;
    logic           instr_ready_q;
    logic           busy_q;
    logic           done_q;
    logic [3:0]     opcode_q;
    logic [3:0]     f4_q;
    logic [4:0]     f5_q;

    logic [1:0]     cw_sel_s;
    logic           cw_call_s;
    logic           cw_end_s;
    logic           cw_pop_s;
    logic [1:0]     err_next_s;
    logic           exec_err_s;
    logic           issue_s;
    logic [DW-1:0]  depth_d;
    logic [15:0]    uop_count_d;
    logic           unused_s;

    assign cw_sel_s  = CW[15:14];
    assign cw_call_s = CW[13];
    assign cw_end_s  = CW[12];
    assign cw_pop_s  = (cw_sel_s == 2'b10);

    // Branch target is consumed by the sequencer, not here.
    assign unused_s = ^{CW[31:16], WD_LIMIT};

    // Classify the current control word; illegal select is checked first,
    // then underflow, then overflow.
    always_comb begin
        err_next_s = 2'b00;
        if (cw_sel_s == 2'b11) begin
            err_next_s = 2'b10;
        end else if (cw_pop_s && stack_empty) begin
            err_next_s = 2'b01;
        end else if (cw_call_s && (depth_q == DEPTH_FULL)) begin
            err_next_s = 2'b10;
        end else begin
            err_next_s = 2'b00;
        end
        exec_err_s = (state_q == S_EXEC) && (err_next_s != 2'b00);
        issue_s    = (state_q == S_EXEC) && (err_next_s == 2'b00);
    end

    // Depth and micro-op counter next values for an issued micro-op; a push
    // and pop together cancel.
    always_comb begin
        depth_d = depth_q;
        case ({cw_call_s, cw_pop_s})
            2'b10:   depth_d = depth_q + DW'(1);
            2'b01:   depth_d = depth_q - DW'(1);
            default: depth_d = depth_q;
        endcase
        if (uop_count_q == 16'hFFFF) begin
            uop_count_d = uop_count_q;
        end else begin
            uop_count_d = uop_count_q + 16'd1;
        end
    end

    // Sequencer-facing strobes; suppressed outside EXEC and on error cycles.
    always_comb begin
        stack_push    = issue_s && cw_call_s;
        load_ret_addr = issue_s && cw_call_s;
        stack_pop     = issue_s && cw_pop_s;
        dp_valid      = issue_s;
        if (issue_s) begin
            dp_ctrl = CW[DP_WIDTH-1:0];
        end else begin
            dp_ctrl = {DP_WIDTH{1'b0}};
        end
        case (state_q)
            S_DISPATCH: uCode_Addr = 2'b11;
            S_EXEC: begin
                if (issue_s) begin
                    uCode_Addr = cw_sel_s;
                end else begin
                    uCode_Addr = 2'b00;
                end
            end
            default:    uCode_Addr = 2'b00;
        endcase
    end

    // Main FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            depth_q       <= {DW{1'b0}};
            uop_count_q   <= 16'd0;
            err_code_q    <= 2'b00;
            instr_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            opcode_q      <= 4'd0;
            f4_q          <= 4'd0;
            f5_q          <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (instr_valid) begin
                        opcode_q      <= instr_opcode;
                        f4_q          <= instr_f4;
                        f5_q          <= instr_f5;
                        uop_count_q   <= 16'd0;
                        instr_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    depth_q <= {DW{1'b0}};
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (exec_err_s) begin
                        err_code_q <= err_next_s;
                        state_q    <= S_ERR;
                    end else begin
                        uop_count_q <= uop_count_d;
                        depth_q     <= depth_d;
                        if (cw_end_s) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
`ifdef UOP_WATCHDOG_EN
                        // Count including this micro-op has hit the limit.
                        else if (({1'b0, uop_count_q} + 17'd1) >= WD_LIMIT) begin
                            err_code_q <= 2'b11;
                            state_q    <= S_ERR;
                        end
`endif
                    end
                end
                S_DONE: begin
                    done_q        <= 1'b0;
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                S_ERR: begin
                    if (err_clr) begin
                        err_code_q    <= 2'b00;
                        instr_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end
                end
                default: begin
                    instr_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready  = instr_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_code     = err_code_q;
    assign uop_count    = uop_count_q;
    assign opcode       = opcode_q;
    assign function4bit = f4_q;
    assign function5bit = f5_q;

endmodule

// File: doc/uinstr_issue_ctrl.md
UINSTR_ISSUE_CTRL -- requirements
Module: uinstr_issue_ctrl

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4; return-stack depth, equal to the sequencer stack depth.
REQ-002 SHALL have parameter MAX_UOPS, default 1024; watchdog limit on EXEC cycles per instruction.
REQ-003 SHALL have parameter DP_WIDTH, default 12; width of the datapath control field.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous active-low reset.
- instr_valid  in  1  host instruction valid.
- instr_ready  out  1  accept strobe to host.
- instr_opcode  in  4  host opcode.
- instr_f4  in  4  host 4-bit function field.
- instr_f5  in  5  host 5-bit function field.
- CW  in  32  control word from control memory.
- stack_empty  in  1  sequencer return-stack empty.
- err_clr  in  1  clears the error state.
- opcode  out  4  latched opcode to the sequencer.
- function4bit  out  4  latched 4-bit function to the sequencer.
- function5bit  out  5  latched 5-bit function to the sequencer.
- uCode_Addr  out  2  next-address select to the sequencer.
- stack_push  out  1  push return address.
- stack_pop  out  1  pop return address.
- load_ret_addr  out  1  return-address load strobe.
- dp_ctrl  out  DP_WIDTH  datapath controls, valid when dp_valid=1.
- dp_valid  out  1  micro-op issued this cycle.
- done  out  1  one-cycle end-of-instruction pulse.
- busy  out  1  high in every state other than IDLE.
- err_code  out  2  sticky error: 00 none, 01 underflow, 10 overflow/illegal, 11 timeout.
- uop_count  out  16  EXEC cycles in the current instruction.

Function
REQ-006 SHALL use the CW fields: [31:16] branch target (sequencer only); [15:14] select (00 increment, 01 branch, 10 return); [13] call; [12] end; [DP_WIDTH-1:0] dp_ctrl.
REQ-007 SHALL implement the FSM IDLE -> DISPATCH -> WAIT -> EXEC -> DONE -> IDLE, plus ERR.
REQ-008 In IDLE: instr_ready=1; on instr_valid, latch opcode, function4bit and function5bit, clear uop_count, and go to DISPATCH.
REQ-009 In DISPATCH, for one cycle: uCode_Addr=2'b11, which selects the dispatch address and clears the sequencer stack; the local depth counter is cleared.
REQ-010 In WAIT, for one cycle: uCode_Addr=2'b00; this absorbs the 1-cycle control-memory read latency.
REQ-011 In EXEC, each cycle:
- uCode_Addr=CW[15:14];
- dp_ctrl=CW[DP_WIDTH-1:0] and dp_valid=1;
- uop_count increments, saturating at 16'hFFFF.
REQ-012 In EXEC, CW[13]=1 SHALL assert stack_push and load_ret_addr for that cycle and increment the depth counter.
REQ-013 In EXEC, CW[15:14]=10 SHALL assert stack_pop for that cycle and decrement the depth counter.
REQ-014 In EXEC, CW[12]=1 SHALL go to DONE after the current micro-op issues.
REQ-015 DONE SHALL assert done for one cycle, drive uCode_Addr=00, then go to IDLE.
REQ-016 Error conditions in EXEC, each of which goes to ERR with no push, pop or dp_valid that cycle:
- pop while stack_empty=1 -> err_code 01;
- push when depth=STACK_DEPTH -> err_code 10;
- CW[15:14]=11 -> err_code 10.
REQ-017 A simultaneous push and pop in one cycle SHALL leave the depth unchanged, with both strobes asserted.
REQ-018 On simultaneous error and end bit, the error SHALL take precedence.
REQ-019 In ERR: err_code held, busy=1, instr_ready=0, all strobes 0; err_clr=1 returns to IDLE and clears err_code.
REQ-020 uCode_Addr SHALL be 00 in IDLE and ERR.
REQ-021 When not in EXEC, stack_push, stack_pop, load_ret_addr and dp_valid SHALL all be 0.
REQ-022 instr_valid SHALL be ignored whenever instr_ready=0.

Reset
REQ-023 With reset_n=0 at a clock edge, the block SHALL enter IDLE.
REQ-024 All outputs SHALL reset to 0 except instr_ready=1; the depth counter and uop_count SHALL be cleared.
REQ-025 Reset SHALL take precedence over every state, including mid-EXEC and ERR.

Configuration
REQ-026 Macro UOP_WATCHDOG_EN:
- Defined: in EXEC, when uop_count reaches MAX_UOPS without an end bit, go to ERR with err_code 11.
- Undefined: no timeout; uop_count only saturates, and err_code 11 is never produced.

Verification
REQ-027 Reset, then send opcode=4'h3 with routine CW selects 00,00 and end on the 3rd micro-op -> DISPATCH uCode_Addr=11; 3 dp_valid cycles; done pulse; uop_count=3; instr_ready back to 1.
REQ-028 Micro-op with CW[13]=1, then 2 ops, then select 10 with end -> push, load_ret_addr and pop each 1 cycle; depth back to 0; err_code 00.
REQ-029 Select 10 while stack_empty=1 -> ERR with err_code 01 and no stack_pop; err_clr=1 -> IDLE with err_code 00.
REQ-030 Five consecutive CW[13]=1 with STACK_DEPTH=4 -> 5th op raises err_code 10 and stack_push stays 0.
REQ-031 UOP_WATCHDOG_EN defined, MAX_UOPS=8, routine with no end bit -> ERR with err_code 11 after 8 EXEC cycles; undefined -> still in EXEC at 20 cycles.
REQ-032 reset_n low mid-EXEC, and instr_valid held high while busy -> IDLE next edge with all strobes 0; no second latch of instr fields while busy.
